fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
Parametrised instruction-fetch front end with a prefetch buffer, generalising the single IF stage of the 5-stage pipeline.
- Owns the PC and issues sequential requests to a synchronous instruction memory (1-cycle read latency).
- Buffers up to DEPTH fetched {pc, instr} entries and hands them to decode over a valid/ready handshake.
- Decode stalls are absorbed by back-pressure instead of PC freezing; branch redirects flush the buffer and any in-flight request.

Parameters:
PC_WIDTH, 9, width of PC and instruction-memory byte address
INSTR_WIDTH, 32, instruction word width
DEPTH, 4, buffer entries; legal range ≥2; ≥3 required for one instruction/cycle sustained
RESET_PC, 0, PC value after reset; must be 4-byte aligned

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
imem_req  out  1  request strobe; imem_addr sampled by memory this edge
imem_addr  out  PC_WIDTH  byte address of requested word, always 4-aligned
imem_rdata  in  INSTR_WIDTH  read data, valid the cycle after imem_req
redirect_valid  in  1  branch/jump taken; flush and restart fetch
redirect_pc  in  PC_WIDTH  new PC; bits [1:0] ignored (treated as 00)
out_valid  out  1  head entry valid
out_ready  in  1  decode accepts head entry this cycle
out_pc  out  PC_WIDTH  PC of head entry
out_instr  out  INSTR_WIDTH  instruction of head entry
count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset (async, any time incl. mid-fetch): pc=RESET_PC, buffer empty, inflight cleared. Outputs: imem_req=0, imem_addr=RESET_PC, out_valid=0, out_pc=0, out_instr=0, count=0.
- State: pc register, inflight flag, inflight_pc register, circular buffer (rd_ptr, wr_ptr, count).
- Issue: imem_req = !rst && !redirect_valid && (count + inflight) < DEPTH.
  - The issue decision never depends on out_ready, so there is no combinational path from out_ready to imem_req.
  - imem_addr = pc, combinational from the register.
  - On issue: pc <= pc+4 modulo 2^PC_WIDTH (wraps to 0), inflight <= 1, inflight_pc <= pc.
  - Otherwise inflight <= 0.
- Response: when inflight=1, imem_rdata is valid this cycle and {inflight_pc, imem_rdata} is pushed at the edge.
  - Overflow is impossible by the issue rule. A bench assertion must check that a push never occurs while count==DEPTH.
- Output: out_valid = count!=0; out_pc/out_instr come straight from the head register (no bypass).
  - Pop occurs when out_valid && out_ready.
  - With out_valid=0, out_pc and out_instr hold 0.
- Latency: request at edge t → entry visible at t+2 → earliest decode accept in cycle t+2.
- Simultaneous push and pop: count unchanged; pointers both advance, wrapping at DEPTH (non-power-of-2 DEPTH legal).
- Redirect (highest priority over push, pop and issue):
  - At the edge: buffer cleared (count=0, pointers=0), inflight <= 0 so the next-cycle imem_rdata is discarded, pc <= {redirect_pc[PC_WIDTH-1:2],2'b00}.
  - No request is issued in the redirect cycle; the first request goes out the cycle after.
  - out_ready during the redirect cycle is ignored (nothing is popped).
- Back-to-back redirects: each overrides the previous; only the last PC is fetched.
- Full buffer with out_ready=0: imem_req=0 and pc holds. No instruction is lost or duplicated.

Decomposition:
- Package fetch_pkg: typedef fetch_entry_t {logic [PC_WIDTH-1:0] pc; logic [INSTR_WIDTH-1:0] instr;} (widths via package constants matching the defaults) and localparam PC_STEP=4.
- One sub-module, fetch_fifo: synchronous circular FIFO with DEPTH parameter, push/pop/flush and count.
  - Flush has priority over push and pop.
  - count is registered; empty/full are derived from count.

Test Plan:
- Reset release, out_ready=1, memory returns word=addr: imem_req high from cycle 1. Addresses 0,4,8,… are issued each cycle. First out_valid in cycle 3 with pc=0 and instr=0, then one entry per cycle in order.
- out_ready=0 for 10 cycles, DEPTH=4: count reaches 4, imem_req drops with imem_addr=0x10 held. Releasing ready drains 0,4,8,0xC, then 0x10 without gaps or duplicates.
- redirect_valid with redirect_pc=0x43 while 3 entries are buffered and 1 is inflight: next cycle count=0 and out_valid=0, the inflight word is dropped, and the next imem_addr=0x40. The first delivered entry has pc=0x40.
- pc=0x1F8, PC_WIDTH=9, continuous fetch: addresses 0x1F8, 0x1FC, 0x000, 0x004; out_pc follows the same wrap.
- Random out_ready (50%) plus random redirects over 5000 cycles, against a reference model: delivered pc sequence matches model, buffer never overflows, and no entry is delivered after a redirect that predates it.
- rst asserted asynchronously mid-cycle with full buffer and inflight: outputs go to reset values immediately without waiting for clk. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the fetch_queue front end.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int FETCH_PC_WIDTH    = 9;
    localparam int FETCH_INSTR_WIDTH = 32;
    localparam int PC_STEP           = 4;

    typedef struct packed {
        logic [FETCH_PC_WIDTH-1:0]    pc;
        logic [FETCH_INSTR_WIDTH-1:0] instr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_if
// Description : Instruction-memory, redirect and decode-side signals of fetch_queue.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_queue_if
    import fetch_pkg::*;
#(
    parameter int PC_WIDTH    = FETCH_PC_WIDTH,
    parameter int INSTR_WIDTH = FETCH_INSTR_WIDTH,
    parameter int DEPTH       = 4
);
    localparam int CNT_WIDTH = $clog2(DEPTH + 1);

    logic                   imem_req;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic [INSTR_WIDTH-1:0] imem_rdata;
    logic                   redirect_valid;
    logic [PC_WIDTH-1:0]    redirect_pc;
    logic                   out_valid;
    logic                   out_ready;
    logic [PC_WIDTH-1:0]    out_pc;
    logic [INSTR_WIDTH-1:0] out_instr;
    logic [CNT_WIDTH-1:0]   count;

    modport master (
        output imem_req, imem_addr, out_valid, out_pc, out_instr, count,
        input  imem_rdata, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_pc, out_instr, count,
        output imem_rdata, redirect_valid, redirect_pc, out_ready
    );

endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Circular FIFO with registered count; flush beats push and pop.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 41,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_push,
    input  wire logic             i_pop,
    input  wire logic             i_flush,
    input  wire logic [WIDTH-1:0] i_data,
    output logic      [WIDTH-1:0] o_data,
    output logic      [CW-1:0]    o_count,
    output logic                  o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;

    // Explicit wrap so non-power-of-two depths stay legal
    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_do_push = i_push && !w_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= f_next(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= f_next(r_rd_ptr);
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : PC owner and prefetch buffer feeding decode over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int                   PC_WIDTH    = FETCH_PC_WIDTH,
    parameter int                   INSTR_WIDTH = FETCH_INSTR_WIDTH,
    parameter int                   DEPTH       = 4,
    parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0
) (
    input  wire logic       clk,
    input  wire logic       rst,
    fetch_queue_if.master   bus
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = PC_WIDTH + INSTR_WIDTH;

    logic [PC_WIDTH-1:0] r_pc;
    logic                r_inflight;
    logic [PC_WIDTH-1:0] r_inflight_pc;
    logic [CW-1:0]       w_count;
    logic [CW:0]         w_occupancy;
    logic                w_issue;
    logic                w_empty;
    logic                w_valid;
    logic                w_pop;
    logic [EW-1:0]       w_head;
    logic [PC_WIDTH-1:0] w_redirect_pc;

    // Issue looks only at occupancy, never at out_ready, so no ready->req path exists
    assign w_occupancy   = {1'b0, w_count} + (CW+1)'(r_inflight);
    assign w_issue       = !rst && !bus.redirect_valid && (w_occupancy < (CW+1)'(DEPTH));
    assign w_redirect_pc = bus.redirect_pc & ~PC_WIDTH'(3);
    assign w_valid       = !w_empty;
    assign w_pop         = w_valid && bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else begin
            r_inflight <= w_issue;
            if (bus.redirect_valid) begin
                r_pc <= w_redirect_pc;
            end else if (w_issue) begin
                r_pc          <= r_pc + PC_WIDTH'(PC_STEP);
                r_inflight_pc <= r_pc;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_inflight),
        .i_pop   (w_pop),
        .i_flush (bus.redirect_valid),
        .i_data  ({r_inflight_pc, bus.imem_rdata}),
        .o_data  (w_head),
        .o_count (w_count),
        .o_empty (w_empty)
    );

    assign bus.imem_req  = w_issue;
    assign bus.imem_addr = r_pc;
    assign bus.out_valid = w_valid;
    assign bus.out_pc    = w_valid ? w_head[EW-1 -: PC_WIDTH] : '0;
    assign bus.out_instr = w_valid ? w_head[INSTR_WIDTH-1:0] : '0;
    assign bus.count     = w_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue
// Description : Directed and randomised checks of fetch_queue against a pc scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    int   deliveries = 0;
    logic infl_m = 1'b0;
    fetch_entry_t sb;

    always #5 clk = ~clk;

    fetch_queue_if #(.PC_WIDTH(9), .INSTR_WIDTH(32), .DEPTH(DEPTH)) bus ();

    fetch_queue #(
        .PC_WIDTH    (9),
        .INSTR_WIDTH (32),
        .DEPTH       (DEPTH),
        .RESET_PC    (9'h000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    function automatic logic [31:0] word(input logic [8:0] a);
        return 32'hC0DE_0000 | 32'(a);
    endfunction

    // Synchronous instruction memory, one-cycle read latency
    always @(posedge clk)
        bus.imem_rdata <= bus.imem_req ? word(bus.imem_addr) : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: scoreboard the handshake seen before the edge, then advance
    task automatic cyc();
        #1;
        chk("count_bound", 64'(bus.count <= 3'(DEPTH)), 64'd1);
        if (infl_m && !bus.redirect_valid)
            chk("push_into_full", 64'(bus.count == 3'(DEPTH)), 64'd0);
        if (bus.redirect_valid) begin
            sb.pc = bus.redirect_pc & 9'h1FC;
        end else if (bus.out_valid && bus.out_ready) begin
            sb.instr = word(sb.pc);
            chk("deliver_pc", bus.out_pc, sb.pc);
            chk("deliver_instr", bus.out_instr, sb.instr);
            sb.pc = sb.pc + 9'(PC_STEP);
            deliveries++;
        end
        infl_m = bus.imem_req;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.out_ready      = 1'b1;
        sb                 = '0;

        // Reset values
        #2;
        chk("rst_req", bus.imem_req, 0);
        chk("rst_addr", bus.imem_addr, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_pc", bus.out_pc, 0);
        chk("rst_instr", bus.out_instr, 0);
        chk("rst_count", bus.count, 0);

        // Streaming with decode always ready
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("s_req0", bus.imem_req, 1);
        chk("s_addr0", bus.imem_addr, 9'h000);
        cyc();
        chk("s_addr1", bus.imem_addr, 9'h004);
        chk("s_valid1", bus.out_valid, 0);
        cyc();
        chk("s_valid2", bus.out_valid, 1);
        chk("s_pc2", bus.out_pc, 9'h000);
        chk("s_instr2", bus.out_instr, 32'hC0DE_0000);
        chk("s_count2", bus.count, 1);
        cyc();
        chk("s_pc3", bus.out_pc, 9'h004);
        cyc();
        chk("s_pc4", bus.out_pc, 9'h008);
        repeat (6) cyc();

        // Back-pressure fills the buffer and freezes the PC
        bus.out_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 9'h000;
        cyc();
        bus.redirect_valid = 1'b0;
        #1;
        chk("bp_count0", bus.count, 0);
        chk("bp_req0", bus.imem_req, 1);
        repeat (10) cyc();
        chk("bp_full_count", bus.count, 4);
        chk("bp_full_req", bus.imem_req, 0);
        chk("bp_full_addr", bus.imem_addr, 9'h010);
        chk("bp_full_pc", bus.out_pc, 9'h000);
        bus.out_ready = 1'b1;
        cyc();
        chk("bp_d1_count", bus.count, 3);
        chk("bp_d1_pc", bus.out_pc, 9'h004);
        chk("bp_d1_req", bus.imem_req, 1);
        chk("bp_d1_addr", bus.imem_addr, 9'h010);
        cyc();
        chk("bp_d2_pc", bus.out_pc, 9'h008);
        chk("bp_d2_count", bus.count, 2);
        cyc();
        chk("bp_d3_pc", bus.out_pc, 9'h00C);
        cyc();
        chk("bp_d4_pc", bus.out_pc, 9'h010);
        chk("bp_d4_valid", bus.out_valid, 1);

        // Redirect with three buffered entries and one in flight
        bus.out_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 9'h000;
        cyc();
        bus.redirect_valid = 1'b0;
        repeat (4) cyc();
        chk("rd_pre_count", bus.count, 3);
        chk("rd_pre_req", bus.imem_req, 0);
        bus.out_ready = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 9'h043;
        #1;
        chk("rd_cycle_req", bus.imem_req, 0);
        cyc();
        chk("rd_count", bus.count, 0);
        chk("rd_valid", bus.out_valid, 0);
        chk("rd_addr", bus.imem_addr, 9'h040);
        bus.redirect_valid = 1'b0;
        #1;
        chk("rd_req_after", bus.imem_req, 1);
        cyc();
        chk("rd_drop_count", bus.count, 0);
        chk("rd_drop_valid", bus.out_valid, 0);
        cyc();
        chk("rd_first_pc", bus.out_pc, 9'h040);
        chk("rd_first_instr", bus.out_instr, 32'hC0DE_0040);
        repeat (3) cyc();

        // PC wrap at the top of the 9-bit address space
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 9'h1F8;
        cyc();
        bus.redirect_valid = 1'b0;
        #1;
        chk("wr_addr0", bus.imem_addr, 9'h1F8);
        cyc();
        chk("wr_addr1", bus.imem_addr, 9'h1FC);
        cyc();
        chk("wr_addr2", bus.imem_addr, 9'h000);
        chk("wr_pc2", bus.out_pc, 9'h1F8);
        cyc();
        chk("wr_addr3", bus.imem_addr, 9'h004);
        chk("wr_pc3", bus.out_pc, 9'h1FC);
        cyc();
        chk("wr_pc4", bus.out_pc, 9'h000);
        repeat (4) cyc();

        // Asynchronous reset mid-cycle with buffered and in-flight work
        bus.out_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 9'h100;
        cyc();
        bus.redirect_valid = 1'b0;
        repeat (4) cyc();
        chk("ar_pre_count", bus.count, 3);
        #3;
        rst = 1'b1;
        #1;
        chk("ar_req", bus.imem_req, 0);
        chk("ar_addr", bus.imem_addr, 9'h000);
        chk("ar_valid", bus.out_valid, 0);
        chk("ar_pc", bus.out_pc, 0);
        chk("ar_instr", bus.out_instr, 0);
        chk("ar_count", bus.count, 0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        sb.pc = 9'h000;
        infl_m = 1'b0;
        #1;
        chk("ar_restart_req", bus.imem_req, 1);
        chk("ar_restart_addr", bus.imem_addr, 9'h000);
        cyc();
        cyc();
        chk("ar_first_pc", bus.out_pc, 9'h000);
        repeat (4) cyc();

        // Random back-pressure and redirects against the scoreboard
        deliveries = 0;
        repeat (5000) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc = 9'($urandom);
            end else begin
                bus.redirect_valid = 1'b0;
            end
            cyc();
        end
        bus.redirect_valid = 1'b0;
        chk("rand_progress", 64'(deliveries > 1000), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
